muldiv_sequencer: RTL

// - Multi-cycle RV32M controller beside the execute-stage ALU. Accepts one MUL/DIV/REM op from

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_if.sv | 22 ++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and funct3 decode helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> multiply/divide sequencer handshake bundle.
interface muldiv_if #(parameter int XLEN = 32);
    logic            StartE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallMD;
    logic            BusyMD;
    logic            DoneMD;
    logic [XLEN-1:0] ResultMD;

    modport master (
        output StartE, funct3E, SrcAE, SrcBE, FlushE,
        input  StallMD, BusyMD, DoneMD, ResultMD
    );

    modport slave (
        input  StartE, funct3E, SrcAE, SrcBE, FlushE,
        output StallMD, BusyMD, DoneMD, ResultMD
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration: shift-add for multiply, restoring shift/subtract for divide.
module muldiv_step #(parameter int XLEN = 32) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            borrow;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        shifted = {hi_i, lo_i[XLEN-1]};
        borrow  = shifted < {1'b0, b_i};
        // Without a borrow the true difference is below b, so the low bits are exact.
        diff    = shifted[XLEN-1:0] - b_i;
        if (is_div_i) begin
            hi_o = borrow ? shifted[XLEN-1:0] : diff;
            lo_o = {lo_i[XLEN-2:0], ~borrow};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M MUL/DIV/REM controller; stalls IF/ID/EX while iterating on magnitudes.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave md
);
    localparam int CW = $clog2(XLEN);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
    logic [2:0]      f3_q, f3_d;
    logic            negp_q, negp_d, nega_q, nega_d, spc_q, spc_d;

    logic            accept, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

    assign accept   = md.StartE & ~md.FlushE;
    assign a_neg    = is_signed_a(md.funct3E) & md.SrcAE[XLEN-1];
    assign b_neg    = is_signed_b(md.funct3E) & md.SrcBE[XLEN-1];
    assign a_mag    = a_neg ? -md.SrcAE : md.SrcAE;
    assign b_mag    = b_neg ? -md.SrcBE : md.SrcBE;
    assign div_zero = (md.SrcBE == '0);
    assign div_ovf  = is_signed_a(md.funct3E) & (md.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) &
                      (md.SrcBE == '1);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div(f3_q)),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Sign fix-up: product sign for MUL*, quotient sign for DIV, dividend sign for REM.
    assign prod     = {hi_q, lo_q};
    assign prod_fix = negp_q ? -prod : prod;
    assign quo_fix  = negp_q ? -lo_q : lo_q;
    assign rem_fix  = nega_q ? -hi_q : hi_q;

    always_comb begin
        fix_res = '0;
        if (spc_q) begin
            fix_res = lo_q;
        end else begin
            case (f3_q)
                F3_MUL:                      fix_res = prod_fix[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:             fix_res = quo_fix;
                default:                     fix_res = rem_fix;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        f3_d    = f3_q;
        negp_d  = negp_q;
        nega_d  = nega_q;
        spc_d   = spc_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d    = md.funct3E;
                    count_d = '0;
                    negp_d  = a_neg ^ b_neg;
                    nega_d  = a_neg;
                    hi_d    = '0;
                    spc_d   = 1'b0;
                    state_d = S_RUN;
                    if (is_div(md.funct3E)) begin
                        lo_d = a_mag;
                        b_d  = b_mag;
                        // Divide-by-zero and signed overflow skip RUN; FIX just publishes lo.
                        if (div_zero || div_ovf) begin
                            spc_d   = 1'b1;
                            state_d = S_FIX;
                            if (md.funct3E[1])
                                lo_d = div_zero ? md.SrcAE : '0;
                            else
                                lo_d = div_zero ? '1 : md.SrcAE;
                        end
                    end else begin
                        lo_d = b_mag;
                        b_d  = a_mag;
                    end
                end
            end
            S_RUN: begin
                if (md.FlushE) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(XLEN-1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (md.FlushE) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = fix_res;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            negp_q  <= 1'b0;
            nega_q  <= 1'b0;
            spc_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            negp_q  <= negp_d;
            nega_q  <= nega_d;
            spc_q   <= spc_d;
            res_q   <= res_d;
        end
    end

    assign md.StallMD  = ((state_q == S_IDLE) && accept) || (state_q == S_RUN) ||
                         (state_q == S_FIX);
    assign md.BusyMD   = (state_q != S_IDLE);
    assign md.DoneMD   = (state_q == S_DONE);
    assign md.ResultMD = res_q;
endmodule
